// File: rtl/wb_data_cache_pkg.sv
// rtl/wb_data_cache_pkg.sv - shared types and constants for the write-back data cache
package wb_data_cache_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        REFILL,
        FL_SCAN,
        FL_WB,
        FL_DONE
    } cache_state_t;

endpackage

// File: rtl/wb_data_cache_line_ram.sv
// rtl/wb_data_cache_line_ram.sv - four byte-lane line storage, byte-enabled write, async read
module wb_data_cache_line_ram
    import wb_data_cache_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [BYTE_W-1:0] mem [1 << AW];

        // Each lane owns one byte of every word; its enable comes straight from the byte mask
        always_ff @(posedge clk) begin
            if (we[l]) begin
                mem[waddr] <= wdata[l*BYTE_W +: BYTE_W];
            end
        end

        assign rdata[l*BYTE_W +: BYTE_W] = mem[raddr];
    end

endmodule

// File: rtl/wb_data_cache.sv
// rtl/wb_data_cache.sv - direct-mapped write-back data cache with flush and hit/miss counters
module wb_data_cache
    import wb_data_cache_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 8,
    parameter int LINE_W  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int TAG_W  = ADDR_W - INDEX_W - LINE_W - 2;
    localparam int RA_W   = INDEX_W + LINE_W;
    localparam int BEAT_W = (LINE_W > 0) ? LINE_W : 1;
    localparam int LINES  = 1 << INDEX_W;
    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'((1 << LINE_W) - 1);
    localparam logic [INDEX_W-1:0] LAST_IDX  = INDEX_W'(LINES - 1);

    cache_state_t       state;
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q [LINES];
    logic [INDEX_W-1:0] idx_q;
    logic [BEAT_W-1:0]  beat_q;
    logic [TAG_W-1:0]   new_tag_q;

    logic [INDEX_W-1:0] cpu_idx;
    logic [TAG_W-1:0]   cpu_tag;
    logic [RA_W-1:0]    cpu_ra;
    logic [RA_W-1:0]    seq_ra;
    logic               lookup_hit;
    logic               store_hit;
    logic               refill_ack;
    logic [3:0]         ram_we;
    logic [RA_W-1:0]    ram_waddr;
    logic [WORD_W-1:0]  ram_wdata;
    logic [RA_W-1:0]    ram_raddr;
    logic [WORD_W-1:0]  ram_rdata;
    logic               unused_byte_bits;

    assign cpu_idx          = cpu_addr[RA_W+1:LINE_W+2];
    assign cpu_tag          = cpu_addr[ADDR_W-1:RA_W+2];
    assign cpu_ra           = cpu_addr[RA_W+1:2];
    assign seq_ra           = (RA_W'(idx_q) << LINE_W) | RA_W'(beat_q);
    assign unused_byte_bits = ^cpu_addr[1:0];

    assign lookup_hit = cpu_req && valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    assign cpu_ready  = (state == IDLE) && lookup_hit;
    assign store_hit  = cpu_ready && cpu_we;
    assign refill_ack = (state == REFILL) && mem_req && mem_ack;

    // Store hits write only their lanes; refill beats write whole words at the sequencer's slot
    assign ram_we    = store_hit ? cpu_be : (refill_ack ? 4'hF : 4'h0);
    assign ram_waddr = store_hit ? cpu_ra : seq_ra;
    assign ram_wdata = store_hit ? cpu_wdata : mem_rdata;
    assign ram_raddr = (state == IDLE) ? cpu_ra : seq_ra;
    assign cpu_rdata = ram_rdata;

    wb_data_cache_line_ram #(.AW(RA_W)) u_line_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Tags are plain storage; the new tag lands together with the last refill beat
    always_ff @(posedge clk) begin
        if (refill_ack && (beat_q == LAST_BEAT)) begin
            tag_q[idx_q] <= new_tag_q;
        end
    end

    // Main controller: lookup, write-back/refill beat sequencing, flush scan, counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            idx_q      <= '0;
            beat_q     <= '0;
            new_tag_q  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            flush_done <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        if (lookup_hit) begin
                            hit_count <= hit_count + 32'd1;
                            if (cpu_we) begin
                                dirty_q[cpu_idx] <= 1'b1;
                            end
                        end else begin
                            miss_count <= miss_count + 32'd1;
                            idx_q      <= cpu_idx;
                            new_tag_q  <= cpu_tag;
                            beat_q     <= '0;
                            state      <= (valid_q[cpu_idx] && dirty_q[cpu_idx]) ? WB : REFILL;
                        end
                    end else if (flush_req) begin
                        idx_q <= '0;
                        state <= FL_SCAN;
                    end
                end
                WB, REFILL, FL_WB: begin
                    if (!mem_req) begin
                        // Present one beat; it stays frozen until the ack is seen
                        mem_req   <= 1'b1;
                        mem_we    <= (state != REFILL);
                        mem_addr  <= (state == REFILL) ? {new_tag_q, seq_ra, 2'b00}
                                                       : {tag_q[idx_q], seq_ra, 2'b00};
                        mem_wdata <= ram_rdata;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        beat_q  <= beat_q + 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            beat_q <= '0;
                            case (state)
                                WB: state <= REFILL;
                                REFILL: begin
                                    valid_q[idx_q] <= 1'b1;
                                    dirty_q[idx_q] <= 1'b0;
                                    state          <= IDLE;
                                end
                                default: begin
                                    dirty_q[idx_q] <= 1'b0;
                                    if (idx_q == LAST_IDX) begin
                                        state      <= FL_DONE;
                                        flush_done <= 1'b1;
                                    end else begin
                                        idx_q <= idx_q + 1'b1;
                                        state <= FL_SCAN;
                                    end
                                end
                            endcase
                        end
                    end
                end
                FL_SCAN: begin
                    if (valid_q[idx_q] && dirty_q[idx_q]) begin
                        beat_q <= '0;
                        state  <= FL_WB;
                    end else if (idx_q == LAST_IDX) begin
                        state      <= FL_DONE;
                        flush_done <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                FL_DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
